// File: rtl/bp_fe_pkg.sv
// FE command types, opcode decode and arbiter state encoding.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int unsigned vaddr_width_gp = 39;
  localparam int unsigned asid_width_gp  = 10;
  localparam int unsigned branch_metadata_width_gp = 8;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_icache_fence         = 3'd3,
    e_op_itlb_fill_response   = 3'd4,
    e_op_itlb_fence           = 3'd5,
    e_op_attaboy              = 3'd6,
    e_op_wait                 = 3'd7
  } bp_fe_command_queue_opcodes_e;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e          opcode;
    logic [asid_width_gp-1:0]              asid;
    logic [vaddr_width_gp-1:0]             vaddr;
    logic [branch_metadata_width_gp-1:0]   branch_metadata;
  } bp_fe_cmd_s;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_full  = 2'd1,
    e_drain = 2'd2
  } bp_fe_cmd_arb_state_e;

  // Commands after which the FE needs a quiet window before the next command.
  function automatic logic is_barrier(input bp_fe_command_queue_opcodes_e op);
    return (op == e_op_state_reset) || (op == e_op_icache_fence);
  endfunction

  // Command width for a given processor configuration.
  function automatic int unsigned fe_cmd_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_fe_cmd_s);
      default:          return $bits(bp_fe_cmd_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_fe_cmd_arb_select.sv
// Priority select: saturated (starving) requesters first, then lowest index.
module bp_fe_cmd_arb_select #(
  parameter int unsigned num_req_p = 4
) (
  input  logic [num_req_p-1:0] v,
  input  logic [num_req_p-1:0] sat,
  output logic [num_req_p-1:0] grant
);

  logic [num_req_p-1:0] pool;

  // Pick the eligible pool, then isolate its lowest set bit.
  always_comb begin
    pool = v & sat;
    if (pool == '0) pool = v;
    grant = pool & (~pool + num_req_p'(1));
  end

endmodule

// File: rtl/bp_fe_cmd_arbiter.sv
// FE command arbiter: fixed-priority grant into a one-entry output slot,
// with a no-grant drain window after barrier commands are consumed.
// Optional starvation aging is enabled by defining BP_FE_CMD_ARB_AGING_EN.
module bp_fe_cmd_arbiter
  import bp_fe_pkg::*;
#(
  parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned drain_cycles_p = 2,
  parameter int unsigned starve_limit_p = 8,
  localparam int unsigned fe_cmd_width_lp = fe_cmd_width_f(bp_params_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*fe_cmd_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  output logic [num_req_p-1:0]                 req_yumi_o,
  output logic [fe_cmd_width_lp-1:0]           fe_cmd_o,
  output logic                                 fe_cmd_v_o,
  input  logic                                 fe_cmd_yumi_i,
  output logic                                 busy_o
);

  localparam int unsigned drain_width_lp = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;
  localparam int unsigned drain_init_lp  = (drain_cycles_p > 0) ? drain_cycles_p - 1 : 0;

  if (num_req_p == 0 || starve_limit_p == 0) begin : g_cfg_check
    $error("bp_fe_cmd_arbiter: num_req_p and starve_limit_p must be nonzero");
  end

  bp_fe_cmd_arb_state_e        state_q, state_n;
  bp_fe_cmd_s                  slot_q, slot_n;
  logic [drain_width_lp-1:0]   drain_cnt_q, drain_cnt_n;
  logic [num_req_p-1:0]        sat, grant;
  logic                        yumi_eff, barrier, grant_en;

  // Slot consumption, barrier detection and grant qualification.
  assign yumi_eff = fe_cmd_yumi_i & (state_q == e_full);
  assign barrier  = yumi_eff & is_barrier(slot_q.opcode) & (drain_cycles_p != 0);
  assign grant_en = reset_i & ((state_q == e_idle) | yumi_eff) & ~barrier;

  bp_fe_cmd_arb_select #(.num_req_p(num_req_p)) select (
    .v     (req_v_i & {num_req_p{grant_en}}),
    .sat   (sat),
    .grant (grant)
  );

  assign req_yumi_o = grant;
  assign fe_cmd_o   = slot_q;
  assign fe_cmd_v_o = (state_q == e_full);
  assign busy_o     = (state_q != e_idle);

`ifdef BP_FE_CMD_ARB_AGING_EN
  localparam int unsigned age_width_lp = $clog2(starve_limit_p + 1);
  logic [num_req_p-1:0][age_width_lp-1:0] age_q;

  // A requester is starving once its wait count reaches the limit.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      sat[i] = (age_q[i] == age_width_lp'(starve_limit_p));
    end
  end

  // Saturating wait counters; frozen while draining.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      age_q <= '0;
    end else if (state_q != e_drain) begin
      for (int i = 0; i < num_req_p; i++) begin
        if (!req_v_i[i] || grant[i]) age_q[i] <= '0;
        else if (!sat[i])            age_q[i] <= age_q[i] + age_width_lp'(1);
      end
    end
  end
`else
  assign sat = '0;
`endif

  // Next state, slot capture and drain countdown.
  always_comb begin
    state_n     = state_q;
    slot_n      = slot_q;
    drain_cnt_n = drain_cnt_q;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) slot_n = bp_fe_cmd_s'(req_cmd_i[i*fe_cmd_width_lp +: fe_cmd_width_lp]);
    end
    case (state_q)
      e_idle: begin
        if (|grant) state_n = e_full;
      end
      e_full: begin
        if (barrier) begin
          state_n     = e_drain;
          drain_cnt_n = drain_width_lp'(drain_init_lp);
        end else if (yumi_eff && !(|grant)) begin
          state_n = e_idle;
        end
      end
      e_drain: begin
        if (drain_cnt_q == '0) state_n = e_idle;
        else                   drain_cnt_n = drain_cnt_q - drain_width_lp'(1);
      end
      default: state_n = e_idle;
    endcase
  end

  // State, slot and drain counter registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= e_idle;
      slot_q      <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      slot_q      <= slot_n;
      drain_cnt_q <= drain_cnt_n;
    end
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_i)
    fe_cmd_yumi_i |-> fe_cmd_v_o);

endmodule

// File: tb/tb_bp_fe_cmd_arbiter.sv
// Bench for bp_fe_cmd_arbiter: directed and random stimulus, reference model
// of slot occupancy / drain window / aging, scoreboard for delivered commands.
module tb_bp_fe_cmd_arbiter;
  import bp_fe_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DRAIN = 2;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned W     = $bits(bp_fe_cmd_s);

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0]   req_v_i;
  logic [N-1:0]   req_yumi_o;
  logic [W-1:0]   fe_cmd_o;
  logic           fe_cmd_v_o;
  logic           fe_cmd_yumi_i;
  logic           busy_o;

  always #5 clk = ~clk;

  bp_fe_cmd_arbiter #(
    .bp_params_p(e_bp_default_cfg), .num_req_p(N),
    .drain_cycles_p(DRAIN), .starve_limit_p(LIMIT)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_cmd_i(req_cmd_i), .req_v_i(req_v_i),
    .req_yumi_o(req_yumi_o), .fe_cmd_o(fe_cmd_o), .fe_cmd_v_o(fe_cmd_v_o),
    .fe_cmd_yumi_i(fe_cmd_yumi_i), .busy_o(busy_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bp_fe_cmd_s sb_q[$];

  // Reference model: is the slot occupied, what it holds, quiet cycles left, wait ages.
  bit         m_full;
  bp_fe_cmd_s m_slot;
  int         m_drain;
  int         m_age[N];
  bp_fe_cmd_s cmds[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_slot  = '0;
    m_drain = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  // One clock of stimulus; force_op < 0 leaves opcodes random.
  task automatic cycle(input logic [N-1:0] v, input bit want_yumi, input int force_op);
    logic [N-1:0] exp_grant;
    bit consumed, barr, can;
    int win;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      cmds[i] = bp_fe_cmd_s'(W'({$urandom, $urandom}));
      if (force_op >= 0) cmds[i].opcode = bp_fe_command_queue_opcodes_e'(3'(force_op));
      req_cmd_i[i*W +: W] = cmds[i];
    end
    req_v_i       = v;
    fe_cmd_yumi_i = want_yumi && m_full;
    #1;
    check("fe_cmd_v", 64'(fe_cmd_v_o), 64'(m_full));
    check("busy", 64'(busy_o), 64'(m_full || m_drain > 0));
    consumed = m_full && fe_cmd_yumi_i;
    barr     = consumed && is_barrier(m_slot.opcode) && (DRAIN > 0);
    can      = (!m_full || consumed) && (m_drain == 0) && !barr;
    win      = -1;
    if (can) begin
`ifdef BP_FE_CMD_ARB_AGING_EN
      for (int i = 0; i < N; i++) if (v[i] && m_age[i] >= LIMIT && win < 0) win = i;
`endif
      for (int i = 0; i < N; i++) if (v[i] && win < 0) win = i;
    end
    exp_grant = '0;
    if (win >= 0) exp_grant[win] = 1'b1;
    check("req_yumi", 64'(req_yumi_o), 64'(exp_grant));
    if (win >= 0) sb_q.push_back(cmds[win]);
    @(posedge clk);
`ifdef BP_FE_CMD_ARB_AGING_EN
    if (m_drain == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || i == win) m_age[i] = 0;
        else if (m_age[i] < LIMIT) m_age[i] = m_age[i] + 1;
      end
    end
`endif
    if (m_drain > 0) m_drain--;
    if (win >= 0) begin
      m_full = 1'b1;
      m_slot = cmds[win];
    end else if (consumed) begin
      m_full = 1'b0;
    end
    if (barr) m_drain = DRAIN;
  endtask

  // Monitor: every presented command must match the oldest granted one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_i === 1'b1 && fe_cmd_v_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(fe_cmd_o), 64'(0) - 64'(1));
        end else begin
          check("fe_cmd_o", 64'(fe_cmd_o), 64'(sb_q[0]));
          if (fe_cmd_yumi_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_i       = 1'b0;
    req_v_i       = '0;
    req_cmd_i     = '0;
    fe_cmd_yumi_i = 1'b0;
    model_reset();
    #1;
    check("reset_v", 64'(fe_cmd_v_o), 64'(0));
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_yumi", 64'(req_yumi_o), 64'(0));
    check("reset_cmd", 64'(fe_cmd_o), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b1;

    // Priority: requester 1 beats requester 3.
    cycle(4'b1010, 1'b0, 1);
    cycle(4'b0000, 1'b1, 1);

    // Back-to-back from requester 0.
    repeat (3) cycle(4'b0001, 1'b1, 1);
    cycle(4'b0000, 1'b1, 1);

    // Backpressure then same-cycle regrant.
    cycle(4'b0100, 1'b0, 1);
    repeat (5) cycle(4'b0100, 1'b0, 1);
    cycle(4'b0100, 1'b1, 1);
    cycle(4'b0000, 1'b1, 1);

    // Barrier drain after icache_fence.
    cycle(4'b0001, 1'b0, 3);
    repeat (4) cycle(4'b0001, 1'b1, 1);
    cycle(4'b0000, 1'b1, 1);

`ifdef BP_FE_CMD_ARB_AGING_EN
    // Starvation: requester 3 competes with requester 0.
    repeat (24) cycle(4'b1001, 1'b1, 1);
    cycle(4'b0000, 1'b1, 1);
`endif

    // Random traffic with random opcodes.
    for (int n = 0; n < 400; n++) cycle(N'($urandom), ($urandom_range(0, 3) != 0), -1);

    // Asynchronous reset while the slot is held.
    cycle(4'b0100, 1'b0, 1);
    cycle(4'b0100, 1'b0, 1);
    @(negedge clk);
    #3 reset_i = 1'b0;
    #1;
    check("midreset_v", 64'(fe_cmd_v_o), 64'(0));
    check("midreset_busy", 64'(busy_o), 64'(0));
    check("midreset_yumi", 64'(req_yumi_o), 64'(0));
    check("midreset_cmd", 64'(fe_cmd_o), 64'(0));
    sb_q.delete();
    model_reset();
    req_v_i       = '0;
    fe_cmd_yumi_i = 1'b0;
    @(posedge clk);
    #2 reset_i = 1'b1;
    cycle(4'b0100, 1'b0, 1);

    for (int n = 0; n < 150; n++) cycle(N'($urandom), ($urandom_range(0, 1) != 0), -1);

    // Flush everything still in flight.
    repeat (6) cycle(4'b0000, 1'b1, 1);
    @(negedge clk);
    #3;
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bp_fe_cmd_arbiter.md
Name: bp_fe_cmd_arbiter

Overview:
- Arbitrates and sequences FE commands from up to num_req_p back-end producers onto the single FE command port.
- Producers include the redirect unit, the trap/CSR unit, the ITLB fill walker and the fence unit.
- Holds the granted command in a one-entry output slot until the FE yumis it.
- Enforces a post-barrier drain window after state_reset and icache_fence commands.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr/paddr/asid/branch-metadata widths for bp_fe_cmd_s.
- num_req_p, 4, number of command producers; index 0 has highest priority.
- drain_cycles_p, 2, cycles with no grants after a barrier command is yumi'd; 0 disables the drain.
- starve_limit_p, 8, wait cycles before a requester is promoted (aging only).
- localparam fe_cmd_width_lp, derived width of bp_fe_cmd_s.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- req_cmd_i  in  num_req_p*fe_cmd_width_lp  packed commands; requester i occupies slice i.
- req_v_i  in  num_req_p  per-requester valid.
- req_yumi_o  out  num_req_p  per-requester accept, one-hot or zero.
- fe_cmd_o  out  fe_cmd_width_lp  registered command to the FE.
- fe_cmd_v_o  out  1  output slot valid.
- fe_cmd_yumi_i  in  1  FE consumed fe_cmd_o this cycle.
- busy_o  out  1  slot valid or drain in progress.

Behaviour:
- Reset value of every output is 0: fe_cmd_v_o=0, req_yumi_o=0, busy_o=0, fe_cmd_o=0.
- Reset forces state e_idle and clears all counters. A command already in the slot is discarded; its requester is not re-notified.
- States:
  - e_idle: slot empty.
  - e_full: slot holds a command.
  - e_drain: barrier drain window.
- Slot free condition: slot_free = e_idle | (e_full & fe_cmd_yumi_i). Grant is allowed only when slot_free and the state is not e_drain.
- Grant: winner = lowest index with req_v_i set.
  - req_yumi_o[winner]=1 in the same cycle. It is combinational, and may depend on fe_cmd_yumi_i.
  - Its command is captured into the slot at the clock edge.
  - fe_cmd_v_o rises the next cycle, so latency is 1 cycle from request to presentation.
- Back-to-back: a yumi and a new grant in the same cycle keeps fe_cmd_v_o high continuously. Throughput is 1 command per cycle.
- fe_cmd_o is stable while fe_cmd_v_o=1 and fe_cmd_yumi_i=0. req_v_i may drop without a yumi; that requester simply loses eligibility.
- Barrier: when fe_cmd_yumi_i=1 and the slot opcode is e_op_state_reset or e_op_icache_fence:
  - If drain_cycles_p>0: go to e_drain with drain_cnt=drain_cycles_p-1. No grant is made in that cycle.
  - In e_drain: no grants. drain_cnt decrements each cycle; at 0, go to e_idle.
  - If drain_cycles_p==0: treat the barrier as a normal command.
- Transitions:
  - e_idle -> e_full on grant.
  - e_full -> e_full on yumi with a new grant, or with no yumi.
  - e_full -> e_idle on yumi with no grant.
  - e_full -> e_drain on barrier yumi.
  - e_drain -> e_idle when the counter reaches 0.
- fe_cmd_yumi_i asserted while fe_cmd_v_o=0 is ignored. An assertion flags a protocol error in simulation.
- busy_o = fe_cmd_v_o | (state==e_drain).

Optional Feature:
- Macro: BP_FE_CMD_ARB_AGING_EN.
- When defined:
  - Each requester has a saturating counter of width $clog2(starve_limit_p+1).
  - The counter increments each cycle req_v_i[i] is set and req_yumi_o[i] is not.
  - It clears on grant or when req_v_i[i]=0.
  - Requesters with a saturated counter win over unsaturated ones; the lowest index wins among saturated requesters.
  - Counters hold during e_drain.
- When undefined: pure fixed priority; no counters are instantiated.

Decomposition:
- bp_fe_pkg additions:
  - State enum bp_fe_cmd_arb_state_e.
  - Barrier-opcode decode helper (function is_barrier on opcode).
- bp_fe_cmd_s and opcode enums remain in the existing FE/BE interface macros.
- One sub-module: bp_fe_cmd_arb_select. It is combinational, takes valid and aging-saturation vectors, and outputs a one-hot grant. This isolates the priority logic for unit testing.

Test Plan:
- Priority: req_v_i=4'b1010 with the slot empty -> req_yumi_o=4'b0010. fe_cmd_o equals slice 1 with fe_cmd_v_o=1 next cycle.
- Back-to-back: fe_cmd_yumi_i held at 1 with req 0 valid for 3 cycles -> 3 grants, fe_cmd_v_o continuously 1, 3 distinct commands delivered in order.
- Backpressure: fe_cmd_yumi_i=0 for 5 cycles with req 2 valid -> req_yumi_o=0 throughout and fe_cmd_o stable. On the cycle yumi=1, req 2 is granted the same cycle.
- Barrier drain: icache_fence yumi'd with drain_cycles_p=2 and req 0 valid -> no grant for 2 cycles, grant on the 3rd, busy_o=1 during the drain.
- Aging (macro on, starve_limit_p=8): req 0 and req 3 continuously valid, FE yumi every cycle -> req 3 granted after 8 consecutive losses, then req 0 resumes.
- Async reset asserted mid-e_full -> fe_cmd_v_o=0 immediately, state e_idle, first grant 1 cycle after reset deasserts.
